// File: rtl/mem_bist_master.sv
// Memory BIST master: writes seed+addr to every word, reads it all back and counts mismatches.
// Results (error count, first failing address) stay valid until the next accepted start.
module mem_bist_master #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [WIDTH-1:0]      seed_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  output logic                  wr_rd_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic [WIDTH-1:0]      rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   MaxErr   = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;
  logic [WIDTH-1:0]      seed_q, seed_d;
  logic [ADDR_WIDTH:0]   err_cnt_q, err_cnt_d;

  logic             busy, xfer, last, start_ok, mismatch;
  logic [WIDTH-1:0] expected;

  assign busy     = (state_q == StWrite) || (state_q == StRead);
  assign xfer     = busy && ready_i;
  assign last     = (addr_q == LastAddr);
  assign expected = seed_q + WIDTH'(addr_q);
  assign mismatch = (rdata_i != expected);
  // Abort wins over start in DONE; in IDLE abort is meaningless and start is taken.
  assign start_ok = start_i && ((state_q == StIdle) || ((state_q == StDone) && !abort_i));

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StWrite;
      StWrite: begin
        if (abort_i)           state_d = StIdle;
        else if (xfer && last) state_d = StRead;
      end
      StRead: begin
        if (abort_i)           state_d = StIdle;
        else if (xfer && last) state_d = StDone;
      end
      StDone:  if (start_ok) state_d = StWrite;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_q      <= '0;
      first_err_q <= '0;
      seed_q      <= '0;
      err_cnt_q   <= '0;
    end else begin
      addr_q      <= addr_d;
      first_err_q <= first_err_d;
      seed_q      <= seed_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    addr_d      = addr_q;
    first_err_d = first_err_q;
    seed_d      = seed_q;
    err_cnt_d   = err_cnt_q;
    if (start_ok) begin
      seed_d      = seed_i;
      addr_d      = '0;
      err_cnt_d   = '0;
      first_err_d = '0;
    end else if (xfer && !abort_i) begin
      addr_d = last ? '0 : addr_q + ADDR_WIDTH'(1);
      if ((state_q == StRead) && mismatch) begin
        if (err_cnt_q != MaxErr) err_cnt_d = err_cnt_q + (ADDR_WIDTH + 1)'(1);
        if (err_cnt_q == '0)     first_err_d = addr_q;
      end
    end
  end

  // Outputs
  always_comb begin
    busy_o           = busy;
    valid_o          = busy;
    wr_rd_o          = (state_q == StWrite);
    wdata_o          = (state_q == StWrite) ? expected : '0;
    addr_o           = addr_q;
    done_o           = (state_q == StDone);
    pass_o           = (state_q == StDone) && (err_cnt_q == '0);
    err_cnt_o        = err_cnt_q;
    first_err_addr_o = first_err_q;
  end

endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: table of whole-run vectors against a responder memory,
// plus hand-written abort, reset and restart sequences.
module tb_mem_bist_master;

  localparam int D = 64;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [15:0] seed_i = 16'h0;
  logic [15:0] rdata_i;
  logic [5:0]  addr_o;
  logic [15:0] wdata_o;
  logic        wr_rd_o, valid_o, busy_o, done_o, pass_o;
  logic [6:0]  err_cnt_o;
  logic [5:0]  first_err_addr_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] mem [D];
  logic [63:0] fault = 64'd0;

  typedef struct {
    logic [15:0] seed;
    int unsigned ready_pct;
    logic [63:0] fault;
    int          exp_err;
    int          exp_first;
    bit          exp_pass;
  } vec_t;

  mem_bist_master dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .seed_i           (seed_i),
    .addr_o           (addr_o),
    .wdata_o          (wdata_o),
    .wr_rd_o          (wr_rd_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .rdata_i          (rdata_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .pass_o           (pass_o),
    .err_cnt_o        (err_cnt_o),
    .first_err_addr_o (first_err_addr_o)
  );

  always #5 clk = ~clk;

  // Responder memory; faulty words read back with the low byte inverted.
  always @(posedge clk) begin
    if (valid_o && ready_i && wr_rd_o) mem[addr_o] <= wdata_o;
  end
  assign rdata_i = mem[addr_o] ^ (fault[addr_o] ? 16'h00FF : 16'h0000);

  function automatic logic [63:0] all_outs();
    return {24'h0, addr_o, wdata_o, wr_rd_o, valid_o, busy_o, done_o, pass_o,
            err_cnt_o, first_err_addr_o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] s);
    seed_i  = s;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Full run; the request stream is predicted from the bench's own transfer counters.
  task automatic run_vec(input vec_t v, input string tag);
    int          nw = 0;
    int          nr = 0;
    int          cycles = 0;
    int          errs_before;
    bit          ewr;
    int          eaddr;
    logic [15:0] ewd;
    fault = v.fault;
    start_run(v.seed);
    while (nr < D && cycles < 4000) begin
      ready_i = ($urandom_range(99) < v.ready_pct);
      ewr   = (nw < D);
      eaddr = ewr ? nw : nr;
      ewd   = ewr ? v.seed + 16'(nw) : 16'h0000;
      errs_before = n_err;
      check($sformatf("%s req cycle %0d", tag, cycles),
            {38'h0, valid_o, busy_o, done_o, wr_rd_o, addr_o, wdata_o},
            {38'h0, 1'b1, 1'b1, 1'b0, ewr, 6'(eaddr), ewd});
      if (n_err != errs_before) break;
      step();
      cycles++;
      if (ready_i) begin
        if (nw < D) nw++;
        else nr++;
      end
    end
    check({tag, " done flags"}, {60'h0, busy_o, valid_o, done_o, pass_o},
          {60'h0, 1'b0, 1'b0, 1'b1, v.exp_pass});
    check({tag, " err_cnt"}, 64'(err_cnt_o), 64'(v.exp_err));
    check({tag, " first_err_addr"}, 64'(first_err_addr_o), 64'(v.exp_first));
    if (v.ready_pct == 100) check({tag, " run length"}, 64'(cycles), 64'(2 * D));
  endtask

  initial begin
    vec_t vecs[5];
    int   k;
    vecs[0] = '{16'h1234, 100, 64'd0, 0, 0, 1'b1};
    vecs[1] = '{16'h1234, 50, 64'd0, 0, 0, 1'b1};
    vecs[2] = '{16'hABCD, 100, (64'd1 << 5) | (64'd1 << 40), 2, 5, 1'b0};
    vecs[3] = '{16'h0000, 30, 64'd1 << 63, 1, 63, 1'b0};
    vecs[4] = '{16'h5555, 100, {64{1'b1}}, 64, 0, 1'b0};
    for (int i = 0; i < D; i++) mem[i] = 16'h0;

    #12;
    check("outputs in reset", all_outs(), 64'h0);
    rst_i = 1'b1;
    step();
    step();
    check("idle after reset", {61'h0, valid_o, busy_o, done_o}, 64'h0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort beats a simultaneous start in DONE; results untouched.
    seed_i  = 16'h0000;
    abort_i = 1'b1;
    start_i = 1'b1;
    step();
    abort_i = 1'b0;
    start_i = 1'b0;
    check("abort beats start in DONE", {55'h0, busy_o, done_o, err_cnt_o},
          {55'h0, 1'b0, 1'b1, 7'd64});

    // Restart from DONE with an all-ones seed: data wraps at addr 1.
    fault   = 64'd0;
    ready_i = 1'b1;
    start_run(16'hFFFF);
    check("restart counters cleared", {51'h0, err_cnt_o, first_err_addr_o}, 64'h0);
    check("restart addr0", {41'h0, addr_o, wdata_o, wr_rd_o}, {41'h0, 6'd0, 16'hFFFF, 1'b1});
    step();
    check("restart addr1 wrap", {41'h0, addr_o, wdata_o, wr_rd_o},
          {41'h0, 6'd1, 16'h0000, 1'b1});
    k = 0;
    while (!done_o && k < 300) begin
      step();
      k++;
    end
    check("restart pass", {62'h0, done_o, pass_o}, 64'h3);

    // Abort while writing addr 20.
    start_run(16'h2222);
    k = 0;
    while (addr_o != 6'd20 && k < 100) begin
      step();
      k++;
    end
    check("abort reached addr 20", {57'h0, wr_rd_o, addr_o}, {57'h0, 1'b1, 6'd20});
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("abort -> idle", {60'h0, valid_o, busy_o, done_o, pass_o}, 64'h0);
    step();
    step();
    check("idle holds after abort", {62'h0, valid_o, busy_o}, 64'h0);
    run_vec(vecs[0], "after abort");

    // Reset while reading addr 30 of a run with a fault at word 5.
    fault   = 64'd1 << 5;
    ready_i = 1'b1;
    start_run(16'h0F0F);
    k = 0;
    while (!(valid_o && !wr_rd_o && addr_o == 6'd30) && k < 200) begin
      step();
      k++;
    end
    check("reached read addr 30", {56'h0, valid_o, wr_rd_o, addr_o}, {56'h0, 1'b1, 1'b0, 6'd30});
    check("errors before reset", {51'h0, err_cnt_o, first_err_addr_o},
          {51'h0, 7'd1, 6'd5});
    #2;
    rst_i = 1'b0;
    #1;
    check("async reset mid-read", all_outs(), 64'h0);
    step();
    step();
    check("outputs held in reset", all_outs(), 64'h0);
    #3;
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("no request after reset %0d", i), {62'h0, valid_o, busy_o}, 64'h0);
    end
    fault = 64'd0;
    run_vec(vecs[0], "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bist_master.md
MEM_BIST_MASTER -- requirements
Module: mem_bist_master

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of memory words tested.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start_i  input  1  request a test run; sampled only in IDLE or DONE.
REQ-007 SHALL have port abort_i  input  1  cancel a run in progress.
REQ-008 SHALL have port seed_i  input  WIDTH  pattern seed; latched on accepted start.
REQ-009 SHALL have port addr_o  output  ADDR_WIDTH  memory address.
REQ-010 SHALL have port wdata_o  output  WIDTH  write data.
REQ-011 SHALL have port wr_rd_o  output  1  1 = write, 0 = read.
REQ-012 SHALL have port valid_o  output  1  request valid.
REQ-013 SHALL have port ready_i  input  1  memory accepts request; for reads, rdata_i is valid in the same cycle.
REQ-014 SHALL have port rdata_i  input  WIDTH  read data from memory.
REQ-015 SHALL have port busy_o  output  1  high in WRITE or READ.
REQ-016 SHALL have port done_o  output  1  high in DONE.
REQ-017 SHALL have port pass_o  output  1  high in DONE when err_cnt_o == 0.
REQ-018 SHALL have port err_cnt_o  output  ADDR_WIDTH+1  count of read mismatches in the current or last run.
REQ-019 SHALL have port first_err_addr_o  output  ADDR_WIDTH  address of the first mismatch; 0 if none.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, READ, DONE.
REQ-021 SHALL define a transfer as valid_o && ready_i at a rising clock edge.
REQ-022 SHALL define expected(a) = (seed_q + a) mod 2^WIDTH, with a zero-extended.
REQ-023 SHALL, on start_i in IDLE or DONE: latch seed_i, clear err_cnt_o and first_err_addr_o, set addr_o = 0, and enter WRITE; valid_o rises on the following cycle.
REQ-024 SHALL drive in WRITE: valid_o = 1, wr_rd_o = 1, wdata_o = expected(addr_o).
REQ-025 SHALL hold addr_o, wdata_o and wr_rd_o stable and valid_o high until a transfer occurs; no withdrawal except on abort or reset.
REQ-026 SHALL increment addr_o on each write transfer; on the transfer at DEPTH-1 it SHALL set addr_o = 0 and enter READ with no idle cycle (valid_o stays 1).
REQ-027 SHALL drive in READ: valid_o = 1, wr_rd_o = 0, wdata_o = 0.
REQ-028 SHALL compare rdata_i against expected(addr_o) on each read transfer.
REQ-029 SHALL, on a mismatch, increment err_cnt_o; on the first mismatch only, it SHALL capture addr_o into first_err_addr_o.
REQ-030 SHALL, on the read transfer at DEPTH-1, complete the comparison and then enter DONE.
REQ-031 SHALL hold in DONE: valid_o = 0 and all results stable until the next start_i.
REQ-032 SHALL, on abort_i in WRITE or READ, enter IDLE at that edge, forcing valid_o = 0 next cycle; results are retained but pass_o stays 0. Abort takes priority over a simultaneous transfer, whose comparison is discarded.
REQ-033 SHALL ignore abort_i in IDLE or DONE; abort_i takes priority over start_i in DONE.
REQ-034 SHALL ignore start_i in WRITE or READ.
REQ-035 SHALL complete a run with ready_i tied high, starting at edge 0, as follows: write transfers at edges 1..DEPTH, read transfers at edges DEPTH+1..2*DEPTH, done_o high after edge 2*DEPTH.
REQ-036 SHALL NOT wrap err_cnt_o; its maximum value is DEPTH.

Reset
REQ-037 SHALL, while rst_i = 0 (asynchronously, including mid-run), force state IDLE and all outputs to 0, and clear seed_q.
REQ-038 SHALL, after rst_i deasserts, remain in IDLE until start_i.

Verification
REQ-039 Bench SHALL cover a clean run: responder memory, ready_i = 1, seed_i = 16'h1234 -> 64 writes with wdata = 16'h1234 + addr, 64 reads, done_o = 1 and pass_o = 1 at cycle 129, err_cnt_o = 0.
REQ-040 Bench SHALL cover backpressure: ready_i random at 50% -> addr_o and wdata_o stable while valid_o && !ready_i, same final result, busy_o high throughout.
REQ-041 Bench SHALL cover fault injection: memory corrupts words 5 and 40 on read -> err_cnt_o = 2, first_err_addr_o = 5, pass_o = 0.
REQ-042 Bench SHALL cover abort: abort_i pulsed during write to addr 20 -> valid_o = 0 next cycle, state IDLE, done_o = 0; a subsequent start_i then gives a clean pass.
REQ-043 Bench SHALL cover reset mid-read: rst_i low at addr 30 of READ -> all outputs 0 immediately; after release, no valid_o until start_i.
REQ-044 Bench SHALL cover restart from DONE: start_i with seed_i = 16'hFFFF -> counters cleared and wdata at addr 1 = 16'h0000 (wrap).
